regfile_write_arbiter: RTL and testbench

- Sequences the single register-file write port (4-bit RegId, WriteReg strobe, 16-bit data) and shares it between two writeback requesters: A (ALU writeback, high priority) and B (memory load return, low priority with anti-starvation).
- After reset, it runs a 16-cycle clear sequence that zeroes every register before granting any requester.
- Outputs feed the register file's write decoder and data input directly.

---
 rtl/regfile_write_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: clears R0..R15 after reset, then shares the port between
// a high-priority requester A and a low-priority requester B with bounded starvation.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [3:0]        a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [3:0]        b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              init_busy,
    output logic [3:0]        RegId,
    output logic              WriteReg,
    output logic [DATA_W-1:0] DstData
);

    typedef enum logic {StInit, StRun} state_e;

    state_e              r_state, w_state_nxt;
    logic [3:0]          r_init_cnt, w_init_cnt_nxt;
    logic [3:0]          r_wait_cnt, w_wait_cnt_nxt;
    logic [3:0]          r_reg_id, w_reg_id_nxt;
    logic                r_write, w_write_nxt;
    logic [DATA_W-1:0]   r_data, w_data_nxt;

    logic w_run, w_starve, w_a_xfer, w_b_xfer, w_zero_en;

    always_comb begin
        w_run     = (r_state == StRun);
        w_zero_en = (ZERO_REG != 0);
        w_starve  = (r_wait_cnt == 4'(MAX_WAIT));
        a_ready   = w_run && a_valid && !(b_valid && w_starve);
        b_ready   = w_run && b_valid && (!a_valid || w_starve);
        w_a_xfer  = a_valid && a_ready;
        w_b_xfer  = b_valid && b_ready;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_wait_cnt_nxt = r_wait_cnt;
        w_reg_id_nxt   = r_reg_id;
        w_write_nxt    = 1'b0;
        w_data_nxt     = r_data;
        case (r_state)
            StInit: begin
                w_reg_id_nxt   = r_init_cnt;
                w_data_nxt     = '0;
                w_write_nxt    = 1'b1;
                w_init_cnt_nxt = r_init_cnt + 4'd1;
                w_wait_cnt_nxt = 4'd0;
                if (r_init_cnt == 4'd15) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (w_a_xfer) begin
                    w_reg_id_nxt = a_reg;
                    w_data_nxt   = a_data;
                    w_write_nxt  = !(w_zero_en && (a_reg == 4'd0));
                end else if (w_b_xfer) begin
                    w_reg_id_nxt = b_reg;
                    w_data_nxt   = b_data;
                    w_write_nxt  = !(w_zero_en && (b_reg == 4'd0));
                end
                // Counts consecutive cycles B waited; saturation forces the next grant to B.
                if (!b_valid || w_b_xfer) begin
                    w_wait_cnt_nxt = 4'd0;
                end else if (!w_starve) begin
                    w_wait_cnt_nxt = r_wait_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = StInit;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StInit;
            r_init_cnt <= 4'd0;
            r_wait_cnt <= 4'd0;
            r_reg_id   <= 4'd0;
            r_write    <= 1'b0;
            r_data     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_reg_id   <= w_reg_id_nxt;
            r_write    <= w_write_nxt;
            r_data     <= w_data_nxt;
        end
    end

    assign init_busy = (r_state == StInit);
    assign RegId     = r_reg_id;
    assign WriteReg  = r_write;
    assign DstData   = r_data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: one instance with ZERO_REG=1, one with ZERO_REG=0,
// both driven by the same stimulus.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic [3:0]  a_reg, b_reg;
    logic [15:0] a_data, b_data;

    logic        a_ready, b_ready, init_busy, WriteReg;
    logic [3:0]  RegId;
    logic [15:0] DstData;
    logic        a_ready0, b_ready0, init_busy0, WriteReg0;
    logic [3:0]  RegId0;
    logic [15:0] DstData0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_W(16), .MAX_WAIT(3), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .init_busy(init_busy), .RegId(RegId), .WriteReg(WriteReg), .DstData(DstData)
    );

    regfile_write_arbiter #(.DATA_W(16), .MAX_WAIT(3), .ZERO_REG(0)) u_dut_z0 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready0),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready0),
        .init_busy(init_busy0), .RegId(RegId0), .WriteReg(WriteReg0), .DstData(DstData0)
    );

    typedef struct {
        logic        av;
        logic [3:0]  ar;
        logic [15:0] ad;
        logic        bv;
        logic [3:0]  br;
        logic [15:0] bd;
        logic        ear;
        logic        ebr;
        logic        ew;
        logic        ew0;
        logic [3:0]  ereg;
        logic [15:0] edata;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                                input logic bv, input logic [3:0] br, input logic [15:0] bd,
                                input logic ear, input logic ebr, input logic ew,
                                input logic ew0, input logic [3:0] ereg,
                                input logic [15:0] edata);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
        v.ear = ear; v.ebr = ebr; v.ew = ew; v.ew0 = ew0; v.ereg = ereg; v.edata = edata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_regid", 32'(RegId), 32'd0);
        chk("rst_write", 32'(WriteReg), 32'd0);
        chk("rst_data", 32'(DstData), 32'd0);
        chk("rst_busy", 32'(init_busy), 32'd1);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_z0_write", 32'(WriteReg0), 32'd0);
        chk("rst_z0_a_ready", 32'(a_ready0), 32'd0);
    endtask

    // Called just after rst_n releases (between edges); checks the first n clear writes.
    task automatic run_init(input int n);
        for (int k = 0; k < n; k++) begin
            #1;
            chk("init_a_ready", 32'(a_ready), 32'd0);
            chk("init_b_ready", 32'(b_ready), 32'd0);
            @(posedge clk);
            #1;
            chk("init_write", 32'(WriteReg), 32'd1);
            chk("init_regid", 32'(RegId), 32'(k));
            chk("init_data", 32'(DstData), 32'd0);
            chk("init_busy", 32'(init_busy), (k == 15) ? 32'd0 : 32'd1);
            chk("init_z0_write", 32'(WriteReg0), 32'd1);
        end
    endtask

    initial begin
        //            av ar  ad        bv br  bd        ar br w  w0 reg data
        vecs[0]  = mk(1, 5, 16'hBEEF, 0, 0, 16'h0000, 1, 0, 1, 1, 5, 16'hBEEF);
        vecs[1]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 5, 16'hBEEF);
        vecs[2]  = mk(1, 1, 16'h1111, 1, 2, 16'h2222, 1, 0, 1, 1, 1, 16'h1111);
        vecs[3]  = mk(1, 1, 16'h1111, 1, 2, 16'h2222, 1, 0, 1, 1, 1, 16'h1111);
        vecs[4]  = mk(1, 1, 16'h1111, 1, 2, 16'h2222, 1, 0, 1, 1, 1, 16'h1111);
        vecs[5]  = mk(1, 1, 16'h1111, 1, 2, 16'h2222, 0, 1, 1, 1, 2, 16'h2222);
        vecs[6]  = mk(1, 1, 16'h1111, 1, 2, 16'h2222, 1, 0, 1, 1, 1, 16'h1111);
        vecs[7]  = mk(1, 1, 16'h1111, 1, 2, 16'h2222, 1, 0, 1, 1, 1, 16'h1111);
        vecs[8]  = mk(1, 1, 16'h1111, 1, 2, 16'h2222, 1, 0, 1, 1, 1, 16'h1111);
        vecs[9]  = mk(1, 1, 16'h1111, 1, 2, 16'h2222, 0, 1, 1, 1, 2, 16'h2222);
        vecs[10] = mk(0, 0, 16'h0000, 1, 0, 16'h1234, 0, 1, 0, 1, 0, 16'h1234);
        vecs[11] = mk(0, 0, 16'h0000, 1, 3, 16'h5678, 0, 1, 1, 1, 3, 16'h5678);
        vecs[12] = mk(1, 0, 16'hAAAA, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 16'hAAAA);
        vecs[13] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'hAAAA);
        vecs[14] = mk(1, 1, 16'h1111, 1, 2, 16'h2222, 1, 0, 1, 1, 1, 16'h1111);
        vecs[15] = mk(1, 1, 16'h1111, 1, 2, 16'h2222, 1, 0, 1, 1, 1, 16'h1111);
        vecs[16] = mk(1, 1, 16'h1111, 0, 2, 16'h2222, 1, 0, 1, 1, 1, 16'h1111);
        vecs[17] = mk(1, 1, 16'h1111, 1, 2, 16'h2222, 1, 0, 1, 1, 1, 16'h1111);
        vecs[18] = mk(1, 1, 16'h1111, 1, 2, 16'h2222, 1, 0, 1, 1, 1, 16'h1111);
        vecs[19] = mk(1, 1, 16'h1111, 1, 2, 16'h2222, 1, 0, 1, 1, 1, 16'h1111);
        vecs[20] = mk(1, 1, 16'h1111, 1, 2, 16'h2222, 0, 1, 1, 1, 2, 16'h2222);

        // Requests held high through reset and INIT must never be granted there.
        rst_n   = 1'b0;
        a_valid = 1'b1; a_reg = 4'd9; a_data = 16'h9999;
        b_valid = 1'b1; b_reg = 4'd8; b_data = 16'h8888;
        #12;
        chk_reset_state();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset again mid-clear once R0..R6 are out (init_cnt=7).
        run_init(7);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        run_init(16);
        a_valid = 1'b0;
        b_valid = 1'b0;

        for (int i = 0; i < 21; i++) begin
            a_valid = vecs[i].av; a_reg = vecs[i].ar; a_data = vecs[i].ad;
            b_valid = vecs[i].bv; b_reg = vecs[i].br; b_data = vecs[i].bd;
            #1;
            chk($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].ear));
            chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].ebr));
            chk($sformatf("v%0d_z0_a_ready", i), 32'(a_ready0), 32'(vecs[i].ear));
            chk($sformatf("v%0d_z0_b_ready", i), 32'(b_ready0), 32'(vecs[i].ebr));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_write", i), 32'(WriteReg), 32'(vecs[i].ew));
            chk($sformatf("v%0d_regid", i), 32'(RegId), 32'(vecs[i].ereg));
            chk($sformatf("v%0d_data", i), 32'(DstData), 32'(vecs[i].edata));
            chk($sformatf("v%0d_z0_write", i), 32'(WriteReg0), 32'(vecs[i].ew0));
            chk($sformatf("v%0d_z0_regid", i), 32'(RegId0), 32'(vecs[i].ereg));
            chk($sformatf("v%0d_z0_data", i), 32'(DstData0), 32'(vecs[i].edata));
        end

        // A toggling every cycle, B idle: ready follows valid, strobe follows one cycle later.
        b_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_valid = (i % 2 == 0);
            a_reg   = 4'(i + 1);
            a_data  = 16'(i * 16'h0101 + 16'h0010);
            #1;
            chk($sformatf("tog%0d_a_ready", i), 32'(a_ready), 32'(a_valid));
            chk($sformatf("tog%0d_b_ready", i), 32'(b_ready), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("tog%0d_write", i), 32'(WriteReg), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0) begin
                chk($sformatf("tog%0d_regid", i), 32'(RegId), 32'(i + 1));
                chk($sformatf("tog%0d_data", i), 32'(DstData), 32'(i * 16'h0101 + 16'h0010));
            end
        end

        // Reset during RUN with both requesters active, then a full clear sequence again.
        a_valid = 1'b1; a_reg = 4'd6; a_data = 16'h6666;
        b_valid = 1'b1; b_reg = 4'd7; b_data = 16'h7777;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        run_init(16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
